// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared types and helpers for the bit-serial adder.
//                Provides the FSM state type and the bit-counter width
//                helper used by serial_adder.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Width of the bit counter for a WIDTH-bit operand; never below one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : half_adder / full_adder
//  Description : Combinational one-bit adders. full_adder is built from two
//                half_adder instances plus an OR of their carries.
//  Ports (half_adder) : a, b -> sum, cout
//  Ports (full_adder) : a, b, cin -> sum, cout
//  Revision    : 1.0  initial release
// ============================================================================
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .a    (a),
    .b    (b),
    .sum  (w_s0),
    .cout (w_c0)
  );

  half_adder u_ha1 (
    .a    (w_s0),
    .b    (cin),
    .sum  (sum),
    .cout (w_c1)
  );

  // The two half-adder carries can never both be 1, so OR is sufficient.
  assign cout = w_c0 | w_c1;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder computing a + b + cin one bit per clock,
//                LSB first, using a single full-adder cell. Operands enter
//                through a valid/ready handshake; the result leaves through
//                a second valid/ready handshake.
//  Ports       : clk, rst (async, active-high)
//                in_valid/in_ready, a, b, cin       - operand input
//                out_valid/out_ready, sum, cout      - result output
//                busy                                - high in RUN or DONE
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int              c_CW   = cnt_width(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  sa_state_t        r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_sum_next;

  full_adder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
  assign w_sum_next = {w_fa_sum, r_sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_carry  <= cin;
            r_sum_sh <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end

        RUN: begin
          r_sum_sh <= w_sum_next;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_carry  <= w_fa_cout;
          if (r_cnt == c_LAST) begin
            // Result registers are refreshed only here, so outside DONE
            // they keep showing the last completed result.
            r_sum       <= w_sum_next;
            r_cout      <= w_fa_cout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Qualified with rst so the block reports not-ready while reset is held.
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that computes `a + b + cin` one bit per clock, LSB first, with a single full-adder cell. The cell is built from two `half_adder` instances. The block consumes operand pairs through a valid/ready input handshake and presents the sum through a valid/ready output handshake. It is the sequential stage that wraps the half-adder datapath, for area-constrained arithmetic in the lab designs.

## Interface
- `WIDTH`, default 8: operand and sum width in bits, legal range ≥ 2.

- `clk`  in  1  single clock, all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  operand pair `a`, `b`, `cin` is presented
- `in_ready`  out  1  block can accept an operand pair
- `a`  in  WIDTH  operand A
- `b`  in  WIDTH  operand B
- `cin`  in  1  carry-in
- `out_valid`  out  1  `sum` and `cout` are valid
- `out_ready`  in  1  consumer accepts the result
- `sum`  out  WIDTH  (`a + b + cin`) mod 2^WIDTH
- `cout`  out  1  bit WIDTH of `a + b + cin`
- `busy`  out  1  high while in RUN or DONE

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready = 1`.
  - Accept when `in_valid && in_ready` at a rising edge.
  - On accept: load `a` and `b` into shift registers, load `cin` into the carry register, clear the bit counter and the `sum` shift register, go to RUN.
- **RUN**
  - Each edge: the full adder takes `a_sh[0]`, `b_sh[0]` and `carry`.
  - The full-adder sum bit shifts into the MSB of `sum_sh`, with `sum_sh` shifting right.
  - `a_sh` and `b_sh` shift right, `carry <= fa_cout`, and the counter increments.
  - On the edge where the counter equals WIDTH-1: go to DONE.
  - `in_ready = 0`, and `in_valid` is ignored.
- **DONE**
  - `out_valid = 1`.
  - `sum = sum_sh` and `cout = carry`, both held stable until the handshake completes.
  - On `out_valid && out_ready`: go to IDLE.
  - `in_ready = 0`.
- Arithmetic
  - The result is exact modulo 2^(WIDTH+1): `{cout, sum} = a + b + cin`.
  - The counter width is `$clog2(WIDTH)`.
  - The counter does not wrap during an operation, because the RUN exit occurs at WIDTH-1.
- `sum` and `cout` outputs are driven from registers in every state.
  - Outside DONE they show the last completed result, or 0 after reset.
  - Consumers qualify them with `out_valid`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - `a_sh`, `b_sh`, `sum_sh`, `carry` and the counter go to 0.
  - `out_valid = 0`, `busy = 0`, `sum = 0`, `cout = 0`.
  - `in_ready = 0` while `rst` is high, and 1 in the first cycle after release.
- Latency: if the accept happens at edge E, `out_valid` rises after edge E+WIDTH.
- Minimum issue interval is WIDTH+2 cycles: WIDTH RUN cycles, at least one DONE cycle, one IDLE cycle.
- Output handshake:
  - `out_valid` stays high until `out_ready` is sampled high.
  - `out_valid` never drops without a handshake, except on reset.
- No back-to-back accept: a new operand pair is accepted only in IDLE, never in the same cycle as the output handshake.
- Reset mid-RUN or mid-DONE:
  - The operation is abandoned and no `out_valid` pulse is produced for it.
  - `out_valid` falls asynchronously.
- `in_valid` held high through RUN/DONE: the operand is neither consumed nor latched, and is accepted at the first IDLE edge.

## Structure
- Package `serial_adder_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t`.
- Sub-module `full_adder`:
  - Two `half_adder` instances plus an OR of their carries.
  - Ports `a`, `b`, `cin`, `sum`, `cout`, purely combinational.
  - `serial_adder` instantiates exactly one.

## Test plan
All scenarios use WIDTH=8.
- **Reset:** hold `rst` 3 cycles mid-stream → `out_valid=0`, `busy=0`, `sum=8'h00`, `cout=0`, `in_ready=0` during reset and 1 the cycle after release.
- **Full ripple:** `a=8'hFF`, `b=8'h01`, `cin=0` → `sum=8'h00`, `cout=1`, `out_valid` rises exactly 8 edges after accept.
- **Carry-in path:** `a=8'hA5`, `b=8'h5A`, `cin=1` → `sum=8'h00`, `cout=1`. Then `a=8'h12`, `b=8'h34`, `cin=0` → `sum=8'h46`, `cout=0`.
- **Backpressure:**
  - Stimulus: `a=8'h3C`, `b=8'h0F`, `out_ready` low for 5 cycles in DONE, `in_valid` held high with `a=8'h01`.
  - Required: `sum=8'h4B` held stable, `in_ready=0`, second operand not accepted.
  - After `out_ready=1`: IDLE, the second operand is accepted one cycle later and gives `sum=8'h4B`→`8'h01+b`.
- **Reset mid-RUN:** assert `rst` after 3 RUN cycles → no `out_valid` for that operation. Next op `a=8'h80`, `b=8'h80` → `sum=8'h00`, `cout=1`.
- **Randomized sweep:** 1000 random `a`, `b`, `cin` with random `out_ready` stalls → `{cout,sum}` equals the reference model `a+b+cin` every time.
